// File: rtl/sd_mcast_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sd_mcast_pkg
// Purpose  : Shared types and helpers for the multicast arbiter family.
//            rr_next() is a behavioural round-robin search: the first
//            requester at or after ptr, wrapping modulo n.
// Contents : RR_MAX_IN / RR_IDX_MAX - largest requester count supported
//            idx_w()                - index width for n requesters
//            rr_next()              - round-robin winner + valid flag
// Revision : 1.0 - initial release
// ============================================================================
package sd_mcast_pkg;

  localparam int RR_MAX_IN  = 32;
  localparam int RR_IDX_MAX = 5;

  typedef struct packed {
    logic                  valid;
    logic [RR_IDX_MAX-1:0] idx;
  } rr_res_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Requests above bit n-1 are ignored. The loop bound is fixed so the
  // function unrolls into a static priority chain.
  function automatic rr_res_t rr_next(input logic [RR_IDX_MAX-1:0] ptr,
                                      input logic [RR_MAX_IN-1:0]  req,
                                      input int                    n);
    rr_res_t               res;
    logic [RR_IDX_MAX-1:0] j;
    res = '0;
    for (int k = 0; k < RR_MAX_IN; k++) begin
      if (k < n) begin
        j = RR_IDX_MAX'((int'(ptr) + k) % n);
        if (!res.valid && req[j]) begin
          res.valid = 1'b1;
          res.idx   = j;
        end
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : sd_rr_pick
// Purpose  : Combinational round-robin picker. Grants the first requester
//            at or after i_ptr, wrapping modulo N. Reusable by any arbiter.
// Ports    : i_req     [N]  - request vector
//            i_ptr     [IW] - search start index (0..N-1)
//            o_gnt_oh  [N]  - one-hot grant, zero when nothing requests
//            o_gnt_idx [IW] - binary grant index, 0 when nothing requests
// Revision : 1.0 - initial release
// ============================================================================
module sd_rr_pick
  import sd_mcast_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt_oh,
  output logic [IW-1:0] o_gnt_idx
);

  logic [RR_MAX_IN-1:0] w_req_ext;
  rr_res_t              w_res;

  assign w_req_ext = RR_MAX_IN'(i_req);
  assign w_res     = rr_next(RR_IDX_MAX'(i_ptr), w_req_ext, N);
  assign o_gnt_idx = w_res.idx[IW-1:0];

  always_comb begin
    o_gnt_oh = '0;
    for (int i = 0; i < N; i++) begin
      o_gnt_oh[i] = w_res.valid && (w_res.idx == RR_IDX_MAX'(i));
    end
  end

endmodule
`default_nettype wire

// File: rtl/sd_mcast_arb.sv
`default_nettype none
// ============================================================================
// Module   : sd_mcast_arb
// Purpose  : Round-robin arbiter feeding one registered multicast mirror.
//            The winner's word and destination mask are latched and the word
//            is offered to every masked destination. A new word loads only
//            once every destination owed the current word has taken it
//            (including the cycle in which the last one completes).
// Ports    : clk, rst        - clock, synchronous active-high reset
//            c_srdy/c_drdy   - per-requester valid / accept (one-hot or 0)
//            c_data/c_dst    - requester i word / mask at slice i
//            p_srdy/p_drdy   - per-destination valid / ready
//            p_data/p_src    - latched word and its requester index
// Config   : SD_MCAST_ARB_ATOMIC_EN - when defined, all pending destinations
//            complete together, only in a cycle where every one is ready.
// Revision : 1.0 - initial release
// ============================================================================
module sd_mcast_arb
  import sd_mcast_pkg::*;
#(
  parameter int INPUTS     = 4,
  parameter int MIRROR_CNT = 2,
  parameter int WIDTH      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INPUTS-1:0]            c_srdy,
  output logic [INPUTS-1:0]            c_drdy,
  input  logic [INPUTS*WIDTH-1:0]      c_data,
  input  logic [INPUTS*MIRROR_CNT-1:0] c_dst,
  output logic [MIRROR_CNT-1:0]        p_srdy,
  input  logic [MIRROR_CNT-1:0]        p_drdy,
  output logic [WIDTH-1:0]             p_data,
  output logic [$clog2(INPUTS)-1:0]    p_src
);

  localparam int IW = $clog2(INPUTS);

  logic [MIRROR_CNT-1:0] r_pend;
  logic [WIDTH-1:0]      r_data;
  logic [IW-1:0]         r_src;
  logic [IW-1:0]         r_ptr;

  logic [MIRROR_CNT-1:0] w_done;
  logic [MIRROR_CNT-1:0] w_pend_nxt;
  logic                  w_free;
  logic                  w_load;
  logic [INPUTS-1:0]     w_gnt_oh;
  logic [IW-1:0]         w_gnt_idx;
  logic [WIDTH-1:0]      w_sel_data;
  logic [MIRROR_CNT-1:0] w_sel_dst;

`ifdef SD_MCAST_ARB_ATOMIC_EN
  // Every pending destination must be ready before any of them completes.
  assign w_done = (&(p_drdy | ~r_pend)) ? r_pend : '0;
`else
  assign w_done = r_pend & p_drdy;
`endif

  assign w_pend_nxt = r_pend & ~w_done;
  assign w_free     = (w_pend_nxt == '0);

  sd_rr_pick #(
    .N  (INPUTS),
    .IW (IW)
  ) u_pick (
    .i_req     (c_srdy),
    .i_ptr     (r_ptr),
    .o_gnt_oh  (w_gnt_oh),
    .o_gnt_idx (w_gnt_idx)
  );

  assign w_load = w_free && (|w_gnt_oh);
  assign c_drdy = (w_free && !rst) ? w_gnt_oh : '0;

  // AND-OR mux steered by the one-hot grant.
  always_comb begin
    w_sel_data = '0;
    w_sel_dst  = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (w_gnt_oh[i]) begin
        w_sel_data = c_data[i*WIDTH +: WIDTH];
        w_sel_dst  = c_dst[i*MIRROR_CNT +: MIRROR_CNT];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      r_data <= '0;
      r_src  <= '0;
      r_ptr  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_load) begin
        // A zero mask still consumes the request; pend simply stays clear.
        r_pend <= w_sel_dst;
        r_data <= w_sel_data;
        r_src  <= w_gnt_idx;
        r_ptr  <= (w_gnt_idx == IW'(INPUTS - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
    end
  end

  assign p_srdy = r_pend;
  assign p_data = r_data;
  assign p_src  = r_src;

endmodule
`default_nettype wire

// File: tb/tb_sd_mcast_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_mcast_arb
// Purpose  : Scoreboard bench for sd_mcast_arb (4 requesters, 2 destinations,
//            32-bit data). Requesters are queues of words; grants are
//            predicted from round-robin order over the active requesters, and
//            every accepted word is queued once per masked destination.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_mcast_arb;

  localparam int NI = 4;
  localparam int NM = 2;
  localparam int W  = 32;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   src;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NI-1:0]    c_srdy = '0;
  logic [NI-1:0]    c_drdy;
  logic [NI*W-1:0]  c_data = '0;
  logic [NI*NM-1:0] c_dst = '0;
  logic [NM-1:0]    p_srdy;
  logic [NM-1:0]    p_drdy = '0;
  logic [W-1:0]     p_data;
  logic [1:0]       p_src;

  sd_mcast_arb #(.INPUTS(NI), .MIRROR_CNT(NM), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data), .c_dst(c_dst),
    .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data), .p_src(p_src)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] rq_data[NI][$];
  logic [1:0]   rq_dst[NI][$];
  exp_t         sbq[NM][$];
  int           mptr = 0;
  int           waits[NI];
  bit           post_rst = 1'b1;
  bit           pd_rand = 1'b0;
  logic [NM-1:0] pd_fix = '0;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [NM-1:0] pend_m;
    logic [NI-1:0] exp_gnt;
    bit            all_rdy, dlv, free;
    int            w;
    exp_t          e;
    if (rst) begin
      chk(c_drdy == '0, "rst_c_drdy", 64'(c_drdy), 64'(0));
      for (int d = 0; d < NM; d++) sbq[d].delete();
      for (int i = 0; i < NI; i++) waits[i] = 0;
      mptr     = 0;
      post_rst = 1'b1;
    end else begin
      if (post_rst) begin
        chk(p_data == '0, "post_rst_p_data", 64'(p_data), 64'(0));
        chk(p_src == '0, "post_rst_p_src", 64'(p_src), 64'(0));
        post_rst = 1'b0;
      end
      for (int d = 0; d < NM; d++) pend_m[d] = (sbq[d].size() != 0);
      chk(p_srdy == pend_m, "p_srdy", 64'(p_srdy), 64'(pend_m));
      all_rdy = &(p_drdy | ~pend_m);
      for (int d = 0; d < NM; d++) begin
`ifdef SD_MCAST_ARB_ATOMIC_EN
        dlv = pend_m[d] && all_rdy;
`else
        dlv = pend_m[d] && p_drdy[d];
`endif
        if (dlv) begin
          e = sbq[d].pop_front();
          chk(p_data == e.data, "deliver_data", 64'(p_data), 64'(e.data));
          chk(p_src == e.src, "deliver_src", 64'(p_src), 64'(e.src));
        end
      end
      // A new word may be taken once no destination is still owed one.
      free = 1'b1;
      for (int d = 0; d < NM; d++) if (sbq[d].size() != 0) free = 1'b0;
      exp_gnt = '0;
      w = -1;
      if (free) begin
        for (int k = 0; k < NI; k++) begin
          if (w < 0 && c_srdy[(mptr + k) % NI]) w = (mptr + k) % NI;
        end
      end
      if (w >= 0) exp_gnt[w] = 1'b1;
      chk(c_drdy == exp_gnt, "c_drdy_grant", 64'(c_drdy), 64'(exp_gnt));
      if (w >= 0) begin
        for (int d = 0; d < NM; d++) begin
          if (rq_dst[w][0][d]) sbq[d].push_back({rq_data[w][0], 2'(w)});
        end
        for (int i = 0; i < NI; i++) begin
          if (i != w && c_srdy[i]) begin
            waits[i]++;
            if (waits[i] > 3) chk(1'b0, "fairness_wait", 64'(waits[i]), 64'(3));
          end
        end
        waits[w] = 0;
        void'(rq_data[w].pop_front());
        void'(rq_dst[w].pop_front());
        mptr = (w + 1) % NI;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive();
    for (int i = 0; i < NI; i++) begin
      if (rq_data[i].size() > 0) begin
        c_srdy[i]          = 1'b1;
        c_data[i*W +: W]   = rq_data[i][0];
        c_dst[i*NM +: NM]  = rq_dst[i][0];
      end else begin
        c_srdy[i]          = 1'b0;
        c_data[i*W +: W]   = '0;
        c_dst[i*NM +: NM]  = '0;
      end
    end
    if (rst)          p_drdy = '0;
    else if (pd_rand) p_drdy = NM'($urandom_range(0, 3));
    else              p_drdy = pd_fix;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      drive();
    end
  endtask

  task automatic push(input int i, input logic [W-1:0] d, input logic [1:0] m);
    rq_data[i].push_back(d);
    rq_dst[i].push_back(m);
  endtask

  function automatic bit idle();
    for (int i = 0; i < NI; i++) if (rq_data[i].size() != 0) return 1'b0;
    for (int d = 0; d < NM; d++) if (sbq[d].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int maxc);
    int c = 0;
    while (!idle() && c < maxc) begin
      tick(1);
      c++;
    end
    if (!idle()) chk(1'b0, "idle_timeout", 64'(c), 64'(maxc));
    tick(2);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
    tick(1);

    // Two steady requesters, all destinations ready: alternate 0,2,0,2.
    pd_fix = 2'b11;
    for (int k = 0; k < 4; k++) begin
      push(0, 32'h1000_0000 + k, 2'b11);
      push(2, 32'h2000_0000 + k, 2'b11);
    end
    drive();
    wait_idle(40);

    // Destination 1 stalls; a competing requester must wait for pend to clear.
    pd_fix = 2'b01;
    push(1, 32'hA5A5_0001, 2'b11);
    push(3, 32'h3333_0003, 2'b11);
    drive();
    tick(5);
    pd_fix = 2'b11;
    drive();
    wait_idle(40);

    // Zero mask from requester 3, then a normal word from requester 0.
    push(3, 32'hDEAD_0003, 2'b00);
    drive();
    tick(1);
    push(0, 32'hBEEF_0000, 2'b10);
    drive();
    wait_idle(40);

    // Reset while destination 1 is still owed a word.
    pd_fix = 2'b01;
    push(1, 32'h5A5A_0001, 2'b11);
    drive();
    tick(2);
    rst = 1'b1;
    drive();
    tick(1);
    rst = 1'b0;
    pd_fix = 2'b11;
    push(2, 32'h7777_0002, 2'b01);
    push(0, 32'h7777_0000, 2'b11);
    drive();
    wait_idle(40);

    // All four requesters busy, random masks, random destination readiness.
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 40; k++) push(i, $urandom, 2'($urandom_range(0, 3)));
    end
    pd_rand = 1'b1;
    drive();
    wait_idle(6000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
